// File: rtl/music_pkg.sv
// rtl/music_pkg.sv - shared state type, score word fields and pitch table helper for music_player
package music_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_LOAD,
    ST_PLAY
  } state_t;

  localparam int PITCH_MSB = 11;
  localparam int PITCH_LSB = 6;
  localparam int DUR_MSB   = 5;
  localparam int DUR_LSB   = 0;

  localparam logic [5:0] PITCH_REST = 6'd0;
  localparam logic [5:0] PITCH_END  = 6'd63;
  localparam int         NUM_NOTES  = 48;

  localparam int HP_W = 20;

  // Half-period in clock cycles for pitch p, 0 for anything that is not a note.
  // Anchored on A4 = 440 Hz at p = 10, which places p = 1 at C4 = 261.626 Hz.
  function automatic logic [HP_W-1:0] half_period(input logic [5:0] p, input int clk_hz);
    real f;
    if (p == PITCH_REST || int'(p) > NUM_NOTES) return '0;
    f = 440.0 * (2.0 ** ((real'(int'(p)) - 10.0) / 12.0));
    return HP_W'($rtoi(real'(clk_hz) / (2.0 * f) + 0.5));
  endfunction

endpackage

// File: rtl/note_divider_rom.sv
// rtl/note_divider_rom.sv - combinational pitch to tone half-period lookup, 0 for rests
module note_divider_rom
  import music_pkg::*;
#(
  parameter int CLK_HZ = 50000000
) (
  input  logic [5:0]      pitch,
  output logic [HP_W-1:0] half_cycles
);

  logic [HP_W-1:0] hp_table [64];

  for (genvar g = 0; g < 64; g++) begin : g_entry
    assign hp_table[g] = half_period(6'(g), CLK_HZ);
  end

  assign half_cycles = hp_table[pitch];

endmodule

// File: rtl/music_player.sv
// rtl/music_player.sv - score RAM walker and square-wave tone generator; MUSIC_PLAYER_LOOP_EN repeats the score
module music_player
  import music_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 64,
  parameter int ADDR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [11:0]       rd_data,
  output logic              tone,
  output logic [5:0]        note_idx,
  output logic              busy,
  output logic              done
);

  localparam int TICK_CYCLES = CLK_HZ / TICK_HZ;
  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0]     TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  state_t state, state_d;

  logic [5:0]      word_pitch, word_dur;
  logic [HP_W-1:0] rom_half;
  logic [HP_W-1:0] half_q, hp_cnt;
  logic [5:0]      dur_cnt;
  logic [TW-1:0]   tick_cnt;
  logic            play_last;
  logic            addr_clr, addr_inc, note_load, pass_end;

  assign word_pitch = rd_data[PITCH_MSB:PITCH_LSB];
  assign word_dur   = rd_data[DUR_MSB:DUR_LSB];
  assign play_last  = (state == ST_PLAY) && (dur_cnt == 6'd1) && (tick_cnt == '0);

  note_divider_rom #(.CLK_HZ(CLK_HZ)) u_rom (
    .pitch       (word_pitch),
    .half_cycles (rom_half)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  // Next-state decode plus the strobes that steer the address and note datapath.
  always_comb begin
    state_d   = state;
    addr_clr  = 1'b0;
    addr_inc  = 1'b0;
    note_load = 1'b0;
    pass_end  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d  = ST_FETCH;
          addr_clr = 1'b1;
        end
      end
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT:  state_d = ST_LOAD;
      ST_LOAD: begin
        if (word_pitch == PITCH_END) begin
          pass_end = 1'b1;
        end else if (word_dur == 6'd0) begin
          addr_inc = 1'b1;
          state_d  = ST_FETCH;
        end else begin
          note_load = 1'b1;
          state_d   = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (play_last) begin
          if (rd_addr == ADDR_LAST) begin
            pass_end = 1'b1;
          end else begin
            addr_inc = 1'b1;
            state_d  = ST_FETCH;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (pass_end) begin
`ifdef MUSIC_PLAYER_LOOP_EN
      state_d  = ST_FETCH;
      addr_clr = 1'b1;
`else
      state_d  = ST_IDLE;
`endif
    end
    // Abort wins over everything, including a pass that would have ended this cycle.
    if (stop && state != ST_IDLE) begin
      state_d   = ST_IDLE;
      addr_clr  = 1'b0;
      addr_inc  = 1'b0;
      note_load = 1'b0;
      pass_end  = 1'b0;
    end
  end

  // Registered outputs, address counter, duration countdown and tone divider.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en    <= 1'b0;
      rd_addr  <= '0;
      tone     <= 1'b0;
      note_idx <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      half_q   <= '0;
      hp_cnt   <= '0;
      dur_cnt  <= '0;
      tick_cnt <= '0;
    end else begin
      rd_en <= (state_d == ST_FETCH);
      busy  <= (state_d != ST_IDLE);
      done  <= pass_end;
      if (addr_clr)      rd_addr <= '0;
      else if (addr_inc) rd_addr <= rd_addr + ADDR_W'(1);
      if (note_load) begin
        half_q   <= rom_half;
        hp_cnt   <= rom_half - HP_W'(1);
        dur_cnt  <= word_dur;
        tick_cnt <= TICK_LAST;
        tone     <= 1'b0;
        note_idx <= (rom_half != '0) ? word_pitch : 6'd0;
      end else if (state_d == ST_PLAY) begin
        if (tick_cnt == '0) begin
          tick_cnt <= TICK_LAST;
          dur_cnt  <= dur_cnt - 6'd1;
        end else begin
          tick_cnt <= tick_cnt - TW'(1);
        end
        if (half_q != '0) begin
          if (hp_cnt == '0) begin
            hp_cnt <= half_q - HP_W'(1);
            tone   <= ~tone;
          end else begin
            hp_cnt <= hp_cnt - HP_W'(1);
          end
        end
      end else begin
        tone     <= 1'b0;
        note_idx <= '0;
      end
    end
  end

endmodule
